snake_dir_ctrl: RTL

Per-player direction controller for the snake game. It synchronises and debounces active-low direction buttons for NUM_PLAYERS players and rejects 180-degree reversals. Accepted turns are buffered and applied one per game tick. Its registered direction outputs feed the regfile move inputs, replacing the combinational move1/move2 logic in the top level.

---
 rtl/snake_dir_ctrl.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/snake_dir_ctrl.sv
// ---------------------------------------------------------------------------
// snake_dir_ctrl
//
// Per-player direction controller for the snake game.
//
// For each player it does the following:
//   - synchronises the raw active-low buttons;
//   - debounces them;
//   - picks one press per cycle (priority up > right > down > left);
//   - rejects 180-degree reversals and repeats of the reference direction;
//   - buffers surviving turns and applies one per game tick.
//
// The registered dir_out replaces the combinational move logic that used to
// feed the regfile.
//
// Build option:
//   SNAKE_DIR_QUEUE_EN  defined   -> per-player FIFO of QUEUE_DEPTH turns.
//                       undefined -> single "latest wins" pending register;
//                                    QUEUE_DEPTH unused, turn_dropped = 0.
//
// Direction encoding: 1=up, 2=right, 3=down, 4=left.
//
// Ports:
//   clock         in   system clock
//   reset         in   asynchronous active-high reset
//   btn_n         in   [4*NUM_PLAYERS-1:0] raw buttons, active low;
//                      player p uses [4p+3:4p] = {left,down,right,up}
//   tick          in   one-cycle game-step strobe
//   game_restart  in   synchronous clear of directions and pending turns
//   dir_out       out  [3*NUM_PLAYERS-1:0] direction of player p at [3p+2:3p]
//   dir_changed   out  [NUM_PLAYERS-1:0] pulse when dir_out[p] takes a new value
//   turn_dropped  out  [NUM_PLAYERS-1:0] pulse when a legal turn hit a full queue
// ---------------------------------------------------------------------------
module snake_dir_ctrl #(
  parameter int NUM_PLAYERS     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int QUEUE_DEPTH     = 2,
  parameter int INIT_DIR        = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [4*NUM_PLAYERS-1:0] btn_n,
  input  logic                     tick,
  input  logic                     game_restart,
  output logic [3*NUM_PLAYERS-1:0] dir_out,
  output logic [NUM_PLAYERS-1:0]   dir_changed,
  output logic [NUM_PLAYERS-1:0]   turn_dropped
);

  localparam int NB    = 4 * NUM_PLAYERS;
  localparam int DEB_N = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int CNT_W = (DEB_N > 1) ? $clog2(DEB_N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_N - 1);

  // An out-of-range configuration falls back to starting to the right.
  localparam bit CFG_OK = (QUEUE_DEPTH >= 1) && (INIT_DIR >= 1) && (INIT_DIR <= 4);
  localparam logic [2:0] INIT_D = CFG_OK ? 3'(INIT_DIR) : 3'd2;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;
  localparam logic [2:0] DIR_DOWN  = 3'd3;
  localparam logic [2:0] DIR_LEFT  = 3'd4;

  // A turn is refused when it repeats or reverses the reference direction.
  function automatic logic turn_blocked(input logic [2:0] cand,
                                        input logic [2:0] ref_dir);
    logic [2:0] opp;
    case (ref_dir)
      DIR_UP:    opp = DIR_DOWN;
      DIR_RIGHT: opp = DIR_LEFT;
      DIR_DOWN:  opp = DIR_UP;
      DIR_LEFT:  opp = DIR_RIGHT;
      default:   opp = DIR_NONE;
    endcase
    return (cand == ref_dir) || (cand == opp);
  endfunction

  // One press per player per cycle; bit order within a group is {l,d,r,u}.
  function automatic logic [2:0] pick_turn(input logic [3:0] evt);
    if (evt[0])      return DIR_UP;
    else if (evt[1]) return DIR_RIGHT;
    else if (evt[2]) return DIR_DOWN;
    else if (evt[3]) return DIR_LEFT;
    else             return DIR_NONE;
  endfunction

  // -------------------------------------------------------------------------
  // Stage 0: two-flop synchroniser (idle level is released = 1)
  // -------------------------------------------------------------------------
  logic [NB-1:0] sync_a;
  logic [NB-1:0] sync_b;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_a <= '1;
      sync_b <= '1;
    end else begin
      sync_a <= btn_n;
      sync_b <= sync_a;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: debounce and press-event generation
  // -------------------------------------------------------------------------
  // The counter runs only while the synchronised level disagrees with the
  // accepted level. After DEB_N consecutive disagreeing samples the level is
  // accepted. A 1->0 acceptance emits a one-cycle press event.
  logic [NB-1:0]    deb;
  logic [NB-1:0]    press;
  logic [CNT_W-1:0] deb_cnt [NB];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deb   <= '1;
      press <= '0;
      for (int b = 0; b < NB; b++) deb_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        press[b] <= 1'b0;
        if (sync_b[b] != deb[b]) begin
          if (deb_cnt[b] == CNT_LAST) begin
            deb[b]     <= sync_b[b];
            deb_cnt[b] <= '0;
            press[b]   <= deb[b];
          end else begin
            deb_cnt[b] <= deb_cnt[b] + CNT_W'(1);
          end
        end else begin
          deb_cnt[b] <= '0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: per-player arbitration, reversal filter, buffering and apply
  // -------------------------------------------------------------------------
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [2:0] cand_dir;
    logic       cand_vld;
    logic [2:0] cur_dir;
    logic       chg;

    assign cand_dir          = pick_turn(press[4*p +: 4]);
    assign cand_vld          = (cand_dir != DIR_NONE);
    assign dir_out[3*p +: 3] = cur_dir;
    assign dir_changed[p]    = chg;

`ifdef SNAKE_DIR_QUEUE_EN
    localparam int QD   = (QUEUE_DEPTH < 1) ? 1 : QUEUE_DEPTH;
    localparam int QC_W = $clog2(QD + 1);

    logic [2:0]      q_dir [QD];
    logic [QC_W-1:0] q_cnt;
    logic [2:0]      ref_dir;
    logic            turn_ok;
    logic            q_full;
    logic            q_pop;
    logic            q_push;
    logic            q_drop;
    logic            drop;

    // Reference is the newest queued turn, or the live direction if empty.
    // The pre-pop tail is used even when a pop happens this cycle.
    always_comb begin
      ref_dir = cur_dir;
      for (int i = 0; i < QD; i++) begin
        if (q_cnt == QC_W'(i + 1)) ref_dir = q_dir[i];
      end
    end

    assign turn_ok = cand_vld && !turn_blocked(cand_dir, ref_dir);
    assign q_full  = (q_cnt == QC_W'(QD));
    assign q_pop   = tick && (q_cnt != '0);
    assign q_push  = turn_ok && (!q_full || q_pop);
    assign q_drop  = turn_ok && q_full && !q_pop;

    assign turn_dropped[p] = drop;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        q_cnt   <= '0;
        cur_dir <= INIT_D;
        chg     <= 1'b0;
        drop    <= 1'b0;
      end else if (game_restart) begin
        q_cnt   <= '0;
        cur_dir <= INIT_D;
        chg     <= 1'b0;
        drop    <= 1'b0;
      end else begin
        chg  <= q_pop && (q_dir[0] != cur_dir);
        drop <= q_drop;
        if (q_pop) cur_dir <= q_dir[0];
        if (q_push && !q_pop) begin
          q_cnt <= q_cnt + QC_W'(1);
        end else if (q_pop && !q_push) begin
          q_cnt <= q_cnt - QC_W'(1);
        end
      end
    end

    // Shift-register FIFO, head at index 0. On push+pop the new entry lands
    // one slot lower because everything moves down at the same edge.
    always_ff @(posedge clock) begin
      for (int i = 0; i < QD; i++) begin
        if (q_push && (q_pop ? (q_cnt == QC_W'(i + 1)) : (q_cnt == QC_W'(i)))) begin
          q_dir[i] <= cand_dir;
        end else if (q_pop && (i < QD - 1)) begin
          q_dir[i] <= q_dir[(i < QD - 1) ? i + 1 : i];
        end
      end
    end
`else
    logic       pend_vld;
    logic [2:0] pend_dir;
    logic       turn_ok;
    logic       apply;

    assign turn_ok = cand_vld && !turn_blocked(cand_dir, cur_dir);
    assign apply   = tick && pend_vld;

    assign turn_dropped[p] = 1'b0;

    // A new legal turn overwrites the pending one. A turn arriving with the
    // tick is kept for the following tick.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        pend_vld <= 1'b0;
        cur_dir  <= INIT_D;
        chg      <= 1'b0;
      end else if (game_restart) begin
        pend_vld <= 1'b0;
        cur_dir  <= INIT_D;
        chg      <= 1'b0;
      end else begin
        chg <= apply && (pend_dir != cur_dir);
        if (apply) cur_dir <= pend_dir;
        if (turn_ok) begin
          pend_vld <= 1'b1;
        end else if (apply) begin
          pend_vld <= 1'b0;
        end
      end
    end

    always_ff @(posedge clock) begin
      if (turn_ok) pend_dir <= cand_dir;
    end
`endif
  end

endmodule
